// File: rtl/hood_pkg.sv
// Shared types and defaults for the range-hood mode controller and its
// timing sequencer.
package hood_pkg;

    typedef enum logic [2:0] {
        STANDBY,
        MENU,
        LEVEL1,
        LEVEL2,
        LEVEL3,
        CLEAN
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        HURR_RUN,
        HURR_RET,
        CLEAN_RUN
    } tmr_state_e;

    localparam int DEF_CLK_HZ      = 100_000_000;
    localparam int DEF_HURRICANE_S = 60;
    localparam int DEF_RETURN_S    = 60;
    localparam int DEF_CLEAN_S     = 180;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/hood_timer_scheduler_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 and pulses tick on the last count.
// restart forces the count back to 0 so every run starts with a full second.
module sec_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hood_timer_scheduler.sv
// Timing sequencer for the hood: hurricane run, delayed standby, self-clean.
// Optional HOOD_HURR_REARM_EN re-arms the hurricane lockout after a clean.
module hood_timer_scheduler
    import hood_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int HURRICANE_S = DEF_HURRICANE_S,
    parameter int RETURN_S    = DEF_RETURN_S,
    parameter int CLEAN_S     = DEF_CLEAN_S,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             hurricane_req_i,
    input  logic             menu_i,
    input  logic             clean_req_i,
    output logic             hurricane_grant_o,
    output logic             hurricane_done_o,
    output logic             standby_done_o,
    output logic             clean_done_o,
    output logic             busy_o,
    output logic             hurricane_avail_o,
    output logic [CNT_W-1:0] remain_o
);

    localparam logic [CNT_W-1:0] H_CNT = CNT_W'(HURRICANE_S);
    localparam logic [CNT_W-1:0] R_CNT = CNT_W'(RETURN_S);
    localparam logic [CNT_W-1:0] C_CNT = CNT_W'(CLEAN_S);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             avail_q, avail_d;
    logic             grant_q, grant_d;
    logic             hdone_q, hdone_d;
    logic             sdone_q, sdone_d;
    logic             cdone_q, cdone_d;
    logic             tick;
    logic             restart;
    logic             last_sec;

    // Prescaler held at zero while idle and restarted on every state change.
    assign restart = (state_q == IDLE) || (state_d != state_q);

    sec_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    assign last_sec = tick && (remain_q == ONE);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        avail_d  = avail_q;
        grant_d  = 1'b0;
        hdone_d  = 1'b0;
        sdone_d  = 1'b0;
        cdone_d  = 1'b0;
        if (!enable_i) begin
            state_d  = IDLE;
            remain_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clean_req_i) begin
                        state_d  = CLEAN_RUN;
                        remain_d = C_CNT;
                    end else if (hurricane_req_i && avail_q) begin
                        state_d  = HURR_RUN;
                        remain_d = H_CNT;
                        grant_d  = 1'b1;
                        avail_d  = 1'b0;
                    end
                end
                HURR_RUN: begin
                    if (menu_i) begin
                        state_d  = HURR_RET;
                        remain_d = R_CNT;
                    end else if (tick) begin
                        remain_d = remain_q - ONE;
                        if (last_sec) begin
                            state_d = IDLE;
                            hdone_d = 1'b1;
                        end
                    end
                end
                HURR_RET: begin
                    if (tick) begin
                        remain_d = remain_q - ONE;
                        if (last_sec) begin
                            state_d = IDLE;
                            sdone_d = 1'b1;
                        end
                    end
                end
                CLEAN_RUN: begin
                    if (tick) begin
                        remain_d = remain_q - ONE;
                        if (last_sec) begin
                            state_d = IDLE;
                            cdone_d = 1'b1;
`ifdef HOOD_HURR_REARM_EN
                            avail_d = 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remain_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            avail_q  <= 1'b1;
            grant_q  <= 1'b0;
            hdone_q  <= 1'b0;
            sdone_q  <= 1'b0;
            cdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            avail_q  <= avail_d;
            grant_q  <= grant_d;
            hdone_q  <= hdone_d;
            sdone_q  <= sdone_d;
            cdone_q  <= cdone_d;
        end
    end

    assign hurricane_grant_o = grant_q;
    assign hurricane_done_o  = hdone_q;
    assign standby_done_o    = sdone_q;
    assign clean_done_o      = cdone_q;
    assign busy_o            = (state_q != IDLE);
    assign hurricane_avail_o = avail_q;
    assign remain_o          = remain_q;

endmodule

// File: tb/tb_hood_timer_scheduler.sv
// Randomised and directed bench for hood_timer_scheduler against a
// deadline-based reference model.
module tb_hood_timer_scheduler;

    localparam int CLK = 10;
    localparam int HU  = 3;
    localparam int RE  = 2;
    localparam int CL  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable_i = 1'b1;
    logic       hurricane_req_i = 1'b0;
    logic       menu_i = 1'b0;
    logic       clean_req_i = 1'b0;
    logic       hurricane_grant_o;
    logic       hurricane_done_o;
    logic       standby_done_o;
    logic       clean_done_o;
    logic       busy_o;
    logic       hurricane_avail_o;
    logic [7:0] remain_o;

    hood_timer_scheduler #(
        .CLK_HZ     (CLK),
        .HURRICANE_S(HU),
        .RETURN_S   (RE),
        .CLEAN_S    (CL),
        .CNT_W      (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_i         (enable_i),
        .hurricane_req_i  (hurricane_req_i),
        .menu_i           (menu_i),
        .clean_req_i      (clean_req_i),
        .hurricane_grant_o(hurricane_grant_o),
        .hurricane_done_o (hurricane_done_o),
        .standby_done_o   (standby_done_o),
        .clean_done_o     (clean_done_o),
        .busy_o           (busy_o),
        .hurricane_avail_o(hurricane_avail_o),
        .remain_o         (remain_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 hurricane, 2 return, 3 clean.
    int m_mode = 0;
    int m_e0 = 0;
    int m_n = 0;
    int ecnt = 0;
    bit m_avail = 1'b1;
    bit e_grant, e_hd, e_sd, e_cd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_remain();
        if (m_mode == 0) return 0;
        return m_n - (ecnt - m_e0) / CLK;
    endfunction

    task automatic model_edge();
        ecnt++;
        e_grant = 0;
        e_hd = 0;
        e_sd = 0;
        e_cd = 0;
        if (!enable_i) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (clean_req_i) begin
                m_mode = 3; m_e0 = ecnt; m_n = CL;
            end else if (hurricane_req_i && m_avail) begin
                m_mode = 1; m_e0 = ecnt; m_n = HU;
                e_grant = 1; m_avail = 0;
            end
        end else if (m_mode == 1 && menu_i) begin
            m_mode = 2; m_e0 = ecnt; m_n = RE;
        end else if (ecnt - m_e0 == m_n * CLK) begin
            case (m_mode)
                1: e_hd = 1;
                2: e_sd = 1;
                default: begin
                    e_cd = 1;
`ifdef HOOD_HURR_REARM_EN
                    m_avail = 1;
`endif
                end
            endcase
            m_mode = 0;
        end
    endtask

    task automatic compare_all();
        chk("remain", 32'(remain_o), 32'(exp_remain()));
        chk("busy", 32'(busy_o), 32'(m_mode != 0));
        chk("avail", 32'(hurricane_avail_o), 32'(m_avail));
        chk("grant", 32'(hurricane_grant_o), 32'(e_grant));
        chk("hdone", 32'(hurricane_done_o), 32'(e_hd));
        chk("sdone", 32'(standby_done_o), 32'(e_sd));
        chk("cdone", 32'(clean_done_o), 32'(e_cd));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cyc(input logic h, input logic m, input logic c);
        hurricane_req_i = h;
        menu_i = m;
        clean_req_i = c;
        step();
        hurricane_req_i = 1'b0;
        menu_i = 1'b0;
        clean_req_i = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_remain", 32'(remain_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_avail", 32'(hurricane_avail_o), 1);
        chk("rst_pulses", 32'({hurricane_grant_o, hurricane_done_o,
                               standby_done_o, clean_done_o}), 0);
        m_mode = 0;
        m_avail = 1'b1;
        e_grant = 0; e_hd = 0; e_sd = 0; e_cd = 0;
        @(negedge clk);
        compare_all();
        #2 rst_n = 1'b1;
    endtask

    int n;
    bit seen_hd;

    initial begin
        @(negedge clk);
        async_reset();

        // Hurricane grant and full run latency
        cyc(1'b1, 1'b0, 1'b0);
        chk("s1_grant", 32'(hurricane_grant_o), 1);
        chk("s1_rem", 32'(remain_o), HU);
        n = 1;
        while (!hurricane_done_o && n < 100) begin
            step();
            n++;
        end
        chk("s1_latency", n, 31);
        chk("s1_avail", 32'(hurricane_avail_o), 0);

        // Lockout
        cyc(1'b1, 1'b0, 1'b0);
        chk("s2_nogrant", 32'(hurricane_grant_o), 0);
        chk("s2_busy", 32'(busy_o), 0);
`ifdef HOOD_HURR_REARM_EN
        cyc(1'b0, 1'b0, 1'b1);
        repeat (45) step();
        chk("s2_rearm", 32'(hurricane_avail_o), 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s2_regrant", 32'(hurricane_grant_o), 1);
        repeat (35) step();
`endif

        // Menu during hurricane
        async_reset();
        cyc(1'b1, 1'b0, 1'b0);
        repeat (14) step();
        cyc(1'b0, 1'b1, 1'b0);
        chk("s3_rem", 32'(remain_o), RE);
        n = 1;
        seen_hd = 0;
        while (!standby_done_o && n < 100) begin
            step();
            n++;
            if (hurricane_done_o) seen_hd = 1;
        end
        chk("s3_latency", n, 21);
        chk("s3_no_hdone", 32'(seen_hd), 0);

        // Clean beats hurricane in the same cycle
        async_reset();
        cyc(1'b1, 1'b0, 1'b1);
        chk("s4_nogrant", 32'(hurricane_grant_o), 0);
        chk("s4_rem", 32'(remain_o), CL);
        n = 1;
        while (!clean_done_o && n < 100) begin
            step();
            n++;
        end
        chk("s4_latency", n, 41);

        // Power off mid-clean
        cyc(1'b0, 1'b0, 1'b1);
        n = 0;
        while (remain_o != 8'd2 && n < 100) begin
            step();
            n++;
        end
        chk("s5_reach2", 32'(remain_o), 2);
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        chk("s5_rem0", 32'(remain_o), 0);
        chk("s5_idle", 32'(busy_o), 0);
        chk("s5_nodone", 32'(clean_done_o), 0);
        repeat (50) step();

        // Async reset mid-hurricane
        async_reset();
        cyc(1'b1, 1'b0, 1'b0);
        repeat (12) step();
        async_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) async_reset();
            enable_i = ($urandom_range(0, 63) != 0);
            cyc(($urandom_range(0, 15) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 39) == 0));
        end
        enable_i = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hood_timer_scheduler.md
Name: hood_timer_scheduler

Overview:
Timing sequencer for the range-hood mode controller. It owns every timed mode: the 60 s hurricane (level-3) run, the 60 s delayed-standby after menu is pressed during hurricane, and the 180 s self-clean. It also enforces the once-per-power-on hurricane lockout. The mode FSM sends it request pulses and follows its done pulses, so the mode FSM no longer carries any timers.

Parameters:
CLK_HZ, 100_000_000, clk frequency; the 1 s tick period in cycles; must be >= 2
HURRICANE_S, 60, hurricane run length in seconds; must be >= 1
RETURN_S, 60, delayed-standby length after menu is pressed in hurricane; must be >= 1
CLEAN_S, 180, self-clean length in seconds; must be >= 1
CNT_W, 8, width of the seconds counter; must satisfy 2^CNT_W > max of the three lengths

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  power on; low aborts any run
hurricane_req_i  in  1  one-cycle pulse: hurricane key pressed in menu
menu_i  in  1  one-cycle pulse: menu key pressed
clean_req_i  in  1  one-cycle pulse: self-clean key pressed in menu
hurricane_grant_o  out  1  one-cycle pulse: hurricane accepted
hurricane_done_o  out  1  one-cycle pulse: hurricane expired; mode FSM goes to level 2
standby_done_o  out  1  one-cycle pulse: delayed standby expired; mode FSM goes to standby
clean_done_o  out  1  one-cycle pulse: self-clean expired; mode FSM goes to standby
busy_o  out  1  high in any timed state
hurricane_avail_o  out  1  high while hurricane has not been used since power-on
remain_o  out  CNT_W  seconds remaining, for the display; 0 when idle

Behaviour:
- Reset (async, rst_n=0): state IDLE; remain_o=0; all pulse outputs 0; busy_o=0; hurricane_avail_o=1; prescaler=0.
- States are IDLE, HURR_RUN, HURR_RET and CLEAN_RUN. All outputs are registered.
- Prescaler: counts 0..CLK_HZ-1 and raises sec_tick for one cycle at CLK_HZ-1. It restarts at 0 on every state entry, so the first second is always a full CLK_HZ cycles.
- IDLE, clean_req_i and enable_i both high: go to CLEAN_RUN next cycle with remain_o=CLEAN_S. clean_req_i wins if it arrives in the same cycle as hurricane_req_i.
- IDLE, hurricane_req_i and enable_i both high:
  - If hurricane_avail_o=1: go to HURR_RUN with remain_o=HURRICANE_S. Pulse hurricane_grant_o in that same cycle. hurricane_avail_o drops to 0 the next cycle.
  - If hurricane_avail_o=0: ignore the request; no grant.
- HURR_RUN:
  - Each sec_tick decrements remain_o.
  - On the sec_tick with remain_o=1: remain_o goes to 0, hurricane_done_o pulses and the block returns to IDLE.
  - menu_i: go to HURR_RET with remain_o=RETURN_S and the prescaler restarted. If menu_i coincides with the final tick, menu_i wins and there is no hurricane_done_o.
- HURR_RET: counts down the same way; the final tick pulses standby_done_o and returns to IDLE. menu_i is ignored.
- CLEAN_RUN: counts down the same way; the final tick pulses clean_done_o and returns to IDLE. menu_i is ignored.
- Any request pulse that arrives outside IDLE is ignored.
- Latency: the done pulse is asserted in the cycle after the final sec_tick. Total run time is N*CLK_HZ cycles, +-1, counted from the request.
- enable_i low in any state: the next cycle is IDLE with remain_o=0 and no done pulse. hurricane_avail_o keeps its value, because the lockout is cleared only by rst_n.

Optional Feature:
HOOD_HURR_REARM_EN
- Defined: hurricane_avail_o returns to 1 in the same cycle that clean_done_o pulses.
- Not defined: hurricane_avail_o returns to 1 only on reset.

Decomposition:
- Shared package hood_pkg holds:
  - the mode encoding (STANDBY, MENU, LEVEL1, LEVEL2, LEVEL3, CLEAN);
  - the timer state enum (IDLE, HURR_RUN, HURR_RET, CLEAN_RUN);
  - default second counts and CNT_W.
- One sub-module, sec_tick_gen: the parameterised prescaler, with inputs clk, rst_n and restart, and output tick.

Test Plan:
All scenarios use CLK_HZ=10, HURRICANE_S=3, RETURN_S=2, CLEAN_S=4.
1. Reset, then hurricane_req_i -> hurricane_grant_o the same cycle, remain_o=3; remain_o reaches 2, 1, 0 at 10-cycle spacing; hurricane_done_o 31 cycles after the request; hurricane_avail_o=0.
2. A second hurricane_req_i after scenario 1 -> no grant, busy_o stays 0; with HOOD_HURR_REARM_EN, a completed clean followed by hurricane_req_i -> grant.
3. Hurricane, then menu_i 15 cycles later -> remain_o=2; standby_done_o 21 cycles after menu_i; no hurricane_done_o.
4. clean_req_i and hurricane_req_i in the same cycle -> CLEAN_RUN with remain_o=4, no grant; clean_done_o after 41 cycles.
5. enable_i low during CLEAN_RUN with remain_o=2 -> IDLE and remain_o=0 the next cycle; no done pulse.
6. rst_n asserted mid-HURR_RUN, asynchronously -> outputs return to reset values immediately; hurricane_avail_o=1.
